// File: rtl/johnson_counter_8bit.sv
// 8-bit Johnson (twisted-ring) counter with a 16-state sequence.
// Provides phase, wrap and illegal decodes, and returns to 00 from any illegal state.
module johnson_counter_8bit (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] count,
  output logic [3:0] phase,
  output logic       wrap,
  output logic       illegal
);

  localparam logic [7:0] LAST_STATE = 8'h80;

  logic [6:0] edges;
  logic [6:0] edges_minus_one;
  logic       legal;
  logic [3:0] ones;
  logic [4:0] phase_wide;
  logic [7:0] count_next;

  // Scanning from bit 7 to bit 0, a legal state has at most one 0/1 boundary.
  always_comb begin
    edges           = count[7:1] ^ count[6:0];
    edges_minus_one = edges - 7'd1;
    legal           = ((edges & edges_minus_one) == 7'd0);
  end

  always_comb begin
    ones = 4'd0;
    for (int i = 0; i < 8; i++) begin
      ones = ones + {3'd0, count[i]};
    end
  end

  // Once the MSB is set, the ones drain from the bottom, so the index counts back from 16.
  always_comb begin
    phase_wide = 5'd0;
    if (legal) begin
      if (count[7]) begin
        phase_wide = 5'd16 - {1'b0, ones};
      end else begin
        phase_wide = {1'b0, ones};
      end
    end
    phase   = phase_wide[3:0];
    wrap    = (count == LAST_STATE);
    illegal = ~legal;
  end

  always_comb begin
    count_next = 8'h00;
    if (legal) begin
      count_next = {count[6:0], ~count[7]};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= 8'h00;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: tb/tb_johnson_counter_8bit.sv
// Directed testbench for johnson_counter_8bit: reset, two full periods, mid-sequence
// reset, a between-edge reset glitch and recovery from a forced illegal state.
module tb_johnson_counter_8bit;

  logic       clk;
  logic       reset;
  logic [7:0] count;
  logic [3:0] phase;
  logic       wrap;
  logic       illegal;

  int n_checks;
  int n_pass;

  logic [7:0] seq_tbl [16];
  logic [7:0] prev;

  johnson_counter_8bit dut (
    .clk     (clk),
    .reset   (reset),
    .count   (count),
    .phase   (phase),
    .wrap    (wrap),
    .illegal (illegal)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and land on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_state(input string tag, input int idx);
    check({tag, "_count"},   {24'd0, count},   {24'd0, seq_tbl[idx]});
    check({tag, "_phase"},   {28'd0, phase},   idx[31:0]);
    check({tag, "_wrap"},    {31'd0, wrap},    (idx == 15) ? 32'd1 : 32'd0);
    check({tag, "_illegal"}, {31'd0, illegal}, 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    seq_tbl = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F,
                8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80};

    // Reset held for two edges
    reset = 1'b0;
    step();
    check_state("rst1", 0);
    step();
    check_state("rst2", 0);

    // Two full periods after release
    reset = 1'b1;
    prev  = count;
    for (int k = 1; k <= 32; k++) begin
      step();
      check_state("run", k % 16);
      check("one_bit_change", $countones(count ^ prev), 32'd1);
      prev = count;
    end

    // Run up to F0 then reset mid-sequence
    for (int k = 1; k <= 12; k++) begin
      step();
      check_state("to_f0", k);
    end
    reset = 1'b0;
    step();
    check_state("mid_rst", 0);
    reset = 1'b1;
    step();
    check_state("mid_rel", 1);

    // Reset glitch strictly between edges has no effect
    #2 reset = 1'b0;
    #1 check("glitch_hold", {24'd0, count}, 32'h01);
    #1 reset = 1'b1;
    step();
    check_state("glitch_next", 2);

    // Forced illegal state decodes and self-corrects
    force dut.count = 8'h5A;
    #1;
    check("ill_flag",  {31'd0, illegal}, 32'd1);
    check("ill_phase", {28'd0, phase},   32'd0);
    check("ill_wrap",  {31'd0, wrap},    32'd0);
    release dut.count;
    step();
    check_state("ill_recover", 0);
    step();
    check_state("ill_next", 1);
    step();
    check_state("ill_next2", 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
